// File: rtl/mem_arbiter.sv
// Serialises the M-stage data access and the F-stage instruction fetch onto one
// single-port memory, data first, and freezes the pipeline until both complete.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a pipeline cycle with a fetch and/or data request
// DWAIT | data access on the memory port, waiting for mem_ready
// FWAIT | instruction fetch on the memory port, waiting for mem_ready
// DONE  | one unstalled cycle so the pipeline consumes the read data
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_err
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWAIT = 2'd1,
      FWAIT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wait_cnt;
   logic            f_pend;
   logic [AW-1:0]   f_addr;
   logic            waiting;
   logic            timeout_hit;

   assign waiting     = (state == DWAIT) || (state == FWAIT);
   // Abort on the edge ending the TIMEOUT-th consecutive cycle without mem_ready.
   assign timeout_hit = waiting && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_stall = 1'b0;
      mem_req   = 1'b0;
      case (state)
         IDLE: begin
            mem_stall = if_req | dm_req;
            if (dm_req)      state_nxt = DWAIT;
            else if (if_req) state_nxt = FWAIT;
         end
         DWAIT: begin
            mem_stall = 1'b1;
            mem_req   = 1'b1;
            if (timeout_hit)    state_nxt = DONE;
            else if (mem_ready) state_nxt = f_pend ? FWAIT : DONE;
         end
         FWAIT: begin
            mem_stall = 1'b1;
            mem_req   = 1'b1;
            if (timeout_hit || mem_ready) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt  <= '0;
         f_pend    <= 1'b0;
         f_addr    <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         dm_rdata  <= '0;
         if_rdata  <= '0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (dm_req) begin
                  mem_addr  <= dm_addr;
                  mem_we    <= dm_we;
                  mem_wdata <= dm_wdata;
                  f_pend    <= if_req;
                  f_addr    <= if_addr;
               end else if (if_req) begin
                  mem_addr <= if_addr;
                  mem_we   <= 1'b0;
                  f_pend   <= 1'b0;
               end
            end
            DWAIT: begin
               if (timeout_hit) begin
                  // The fetch is skipped; hand the pipeline a nop.
                  dm_rdata <= '0;
                  if_rdata <= '0;
                  mem_err  <= 1'b1;
                  mem_we   <= 1'b0;
               end else if (mem_ready) begin
                  if (!mem_we) dm_rdata <= mem_rdata;
                  wait_cnt <= '0;
                  mem_we   <= 1'b0;
                  if (f_pend) mem_addr <= f_addr;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            FWAIT: begin
               if (timeout_hit) begin
                  if_rdata <= '0;
                  mem_err  <= 1'b1;
               end else if (mem_ready) begin
                  if_rdata <= mem_rdata;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch (F) and data-memory (M) stages of the pipelined MIPS core. Each pipeline cycle it serialises the pending data access and instruction fetch onto the memory port, data first. It holds `mem_stall` high until both accesses have completed. `mem_stall` is ORed into the stall/enable logic next to the hazard unit's StallF/StallD, so the whole pipeline freezes while memory is busy.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, maximum wait-state cycles per access before abort (≥1)

- `clk` in 1 — clock
- `reset_n` in 1 — asynchronous, active-low reset
- `if_req` in 1 — fetch requested this pipeline cycle
- `if_addr` in AW — PCF
- `if_rdata` out DW — fetched instruction, registered
- `dm_req` in 1 — load/store in M stage
- `dm_we` in 1 — 1 = store
- `dm_addr` in AW — ALUOutM
- `dm_wdata` in DW — WriteDataM
- `dm_rdata` out DW — load data, registered
- `mem_stall` out 1 — freeze pipeline
- `mem_req` out 1 — memory access active
- `mem_we` out 1 — write strobe
- `mem_addr` out AW — memory address
- `mem_wdata` out DW — memory write data
- `mem_ready` in 1 — access complete; one pulse per access
- `mem_rdata` in DW — read data, valid with `mem_ready`
- `mem_err` out 1 — sticky timeout flag

## Operation
- States: IDLE, DWAIT, FWAIT, DONE.
- Reset (async, `reset_n`=0): state IDLE, wait counter 0. All outputs are 0: `if_rdata`, `dm_rdata`, `mem_err`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`.
- Reset asserted mid-access abandons the access immediately and drops `mem_req`.

IDLE
- If `dm_req`=1: latch `dm_we`, `dm_addr`, `dm_wdata`, and latch `if_req` and `if_addr`. Go to DWAIT.
- Else if `if_req`=1: latch `if_addr`. Go to FWAIT.
- Otherwise stay in IDLE.

DWAIT
- Drives the latched data access: `mem_we` = latched `dm_we`.
- On `mem_ready`: if the access is a load, capture `mem_rdata` into `dm_rdata`; a store leaves `dm_rdata` unchanged.
- After `mem_ready`: go to FWAIT if `if_req` was latched, else go to DONE.

FWAIT
- Drives the latched `if_addr` with `mem_we`=0.
- On `mem_ready`: capture `mem_rdata` into `if_rdata`, then go to DONE.

DONE
- Lasts one cycle with `mem_stall`=0, so the pipeline advances and consumes `if_rdata`/`dm_rdata`. Then return to IDLE.

Outputs and side rules
- `mem_stall` = 1 in DWAIT and FWAIT, and in IDLE when (`if_req` | `dm_req`). Otherwise 0.
- `mem_req` = 1 exactly in DWAIT and FWAIT (Moore output).
- `mem_addr`, `mem_we`, `mem_wdata` come from latched registers and are stable for the whole access.
- `mem_ready` is ignored in IDLE and DONE.

Timeout
- The wait counter clears on entry to DWAIT/FWAIT and increments on every wait cycle without `mem_ready`.
- When the counter reaches `TIMEOUT`: set `mem_err`, which stays set until reset. Abort the transaction and go to DONE.
- On abort, the aborted access's rdata register is loaded with 0. If the abort occurs in DWAIT, the fetch is skipped and `if_rdata` is also loaded with 0 (a MIPS nop).

## Timing
- Memory latency L ≥ 1 is defined as `mem_ready` arriving in the L-th cycle that `mem_req` is high.
- Fetch only: 1 IDLE + L FWAIT cycles with `mem_stall`=1, then DONE. Pipeline cycle length = L + 2.
- Load/store plus fetch: 1 + L_d + L_f stall cycles, then DONE.
- Back-to-back accesses: `mem_req` stays high across the DWAIT→FWAIT transition. The address and `mem_we` change in the cycle after `mem_ready`; each `mem_ready` completes exactly one access.
- `if_rdata`/`dm_rdata` update on the clock edge ending the `mem_ready` cycle. They hold until the next capture.

## Test plan
- Fetch only, `if_addr`=0x40, L=1, `mem_rdata`=0x20080005:
  - `mem_stall` 1,1,0 over three cycles.
  - `mem_addr`=0x40, `mem_we`=0.
  - In DONE, `if_rdata`=0x20080005.
- Load plus fetch, `dm_addr`=0x100 returning 0xDEADBEEF, `if_addr`=0x44 returning 0x8C090000, L=2:
  - Data access is issued first.
  - `mem_stall` high for 5 cycles.
  - In DONE, `dm_rdata`=0xDEADBEEF and `if_rdata`=0x8C090000.
- Store plus fetch, `dm_wdata`=0x12345678 to 0x104:
  - First access has `mem_we`=1 with that data and address.
  - Second access has `mem_we`=0.
  - `dm_rdata` keeps its previous value.
- No requests: `mem_stall`=0, `mem_req`=0, state stays IDLE, and `mem_ready` pulses are ignored.
- Timeout, `TIMEOUT`=15, memory never ready in DWAIT:
  - After 15 wait cycles, `mem_err`=1 and the FSM goes to DONE.
  - `dm_rdata`=0 and `if_rdata`=0.
  - `mem_err` stays 1 afterwards.
- Reset mid-FWAIT:
  - `reset_n`=0 asynchronously zeroes `mem_req` and all outputs, and the FSM goes to IDLE.
  - After release, a new fetch completes normally.
